// File: rtl/udp_pkt_sequencer.sv
// -----------------------------------------------------------------------------
// udp_pkt_sequencer
//
// Purpose:
//   Drives the udp_checksum_gen header/payload inputs. For each packet it
//   presents a header request (hdr_valid until accepted), then streams an
//   8-bit AXI-Stream payload of the latched length, then waits an
//   inter-packet gap. A run covers a programmed number of packets, or
//   free-runs until stop. A 16-bit IP identification value advances once per
//   completed packet and persists across runs (only reset clears it).
//
// Optional feature (macro UDP_SEQ_SEQNUM_EN):
//   When defined, payload bytes 0..3 carry the packet index within the run
//   (pkts_sent, big-endian) and the effective payload length is at least 4.
//   When undefined, every byte is FILL_BYTE + index and the minimum length is 1.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start, stop       run control pulses
//   cfg_payload_len   payload bytes per packet (0 behaves as 1)
//   cfg_gap           idle cycles between last payload beat and next header
//   cfg_pkt_count     packets per run, 0 = continuous
//   hdr_valid/ready   header handshake
//   pay_t*            payload AXI-Stream master (tuser tied 0)
//   ip_id             IP identification of the current packet
//   active            run in progress
//   pkts_sent         packets completed in the current/last run
//   done              one-cycle pulse at the end of a run
// -----------------------------------------------------------------------------
module udp_pkt_sequencer #(
  parameter int         LEN_WIDTH = 11,
  parameter int         GAP_WIDTH = 16,
  parameter logic [7:0] FILL_BYTE = 8'h11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_WIDTH-1:0] cfg_payload_len,
  input  logic [GAP_WIDTH-1:0] cfg_gap,
  input  logic [31:0]          cfg_pkt_count,
  output logic                 hdr_valid,
  input  logic                 hdr_ready,
  output logic [7:0]           pay_tdata,
  output logic                 pay_tvalid,
  input  logic                 pay_tready,
  output logic                 pay_tlast,
  output logic                 pay_tuser,
  output logic [15:0]          ip_id,
  output logic                 active,
  output logic [31:0]          pkts_sent,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t               state_q,     state_d;
  logic [LEN_WIDTH-1:0] len_q,       len_d;
  logic [GAP_WIDTH-1:0] gap_q,       gap_d;
  logic [31:0]          count_q,     count_d;
  logic [LEN_WIDTH-1:0] idx_q,       idx_d;
  logic [GAP_WIDTH-1:0] gap_cnt_q,   gap_cnt_d;
  logic [31:0]          pkts_q,      pkts_d;
  logic [15:0]          ip_id_q,     ip_id_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 done_q,      done_d;

  logic [LEN_WIDTH-1:0] len_eff;
  logic                 last_beat;
  logic                 run_ends;
  logic [7:0]           data_byte;

  // Length actually used for the run, after applying the minimum.
  always_comb begin
`ifdef UDP_SEQ_SEQNUM_EN
    len_eff = (cfg_payload_len < LEN_WIDTH'(4)) ? LEN_WIDTH'(4) : cfg_payload_len;
`else
    len_eff = (cfg_payload_len == '0) ? LEN_WIDTH'(1) : cfg_payload_len;
`endif
  end

  assign last_beat = (idx_q == len_q - LEN_WIDTH'(1));

  // A pending stop or a stop arriving with the final beat both end the run
  // at this packet boundary.
  assign run_ends = stop_pend_q || stop ||
                    ((count_q != 32'd0) && ((pkts_q + 32'd1) == count_q));

  // Payload byte for the current index.
  always_comb begin
    data_byte = FILL_BYTE + 8'(idx_q);
`ifdef UDP_SEQ_SEQNUM_EN
    if (idx_q == LEN_WIDTH'(0))      data_byte = pkts_q[31:24];
    else if (idx_q == LEN_WIDTH'(1)) data_byte = pkts_q[23:16];
    else if (idx_q == LEN_WIDTH'(2)) data_byte = pkts_q[15:8];
    else if (idx_q == LEN_WIDTH'(3)) data_byte = pkts_q[7:0];
`endif
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    gap_d       = gap_q;
    count_d     = count_q;
    idx_d       = idx_q;
    gap_cnt_d   = gap_cnt_q;
    pkts_d      = pkts_q;
    ip_id_d     = ip_id_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // start together with stop is treated as a cancelled start.
        if (start && !stop) begin
          len_d       = len_eff;
          gap_d       = cfg_gap;
          count_d     = cfg_pkt_count;
          pkts_d      = 32'd0;
          stop_pend_d = 1'b0;
          state_d     = S_HDR;
        end
      end

      S_HDR: begin
        if (stop) stop_pend_d = 1'b1;
        if (hdr_ready) begin
          idx_d   = '0;
          state_d = S_PAY;
        end
      end

      S_PAY: begin
        if (stop) stop_pend_d = 1'b1;
        if (pay_tready) begin
          if (!last_beat) begin
            idx_d = idx_q + LEN_WIDTH'(1);
          end else begin
            pkts_d  = pkts_q + 32'd1;
            ip_id_d = ip_id_q + 16'd1;
            if (run_ends) begin
              state_d     = S_IDLE;
              done_d      = 1'b1;
              stop_pend_d = 1'b0;
            end else if (gap_q == '0) begin
              state_d = S_HDR;
            end else begin
              gap_cnt_d = gap_q;
              state_d   = S_GAP;
            end
          end
        end
      end

      S_GAP: begin
        // The counter holds the number of GAP cycles still to spend,
        // including this one, so the header follows cfg_gap+1 cycles
        // after the last beat.
        if (stop) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
        end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
          state_d = S_HDR;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      gap_q       <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      gap_cnt_q   <= '0;
      pkts_q      <= '0;
      ip_id_q     <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      gap_cnt_q   <= gap_cnt_d;
      pkts_q      <= pkts_d;
      ip_id_q     <= ip_id_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  // Outputs decode registered state only; ready never reaches valid.
  assign hdr_valid  = (state_q == S_HDR);
  assign pay_tvalid = (state_q == S_PAY);
  assign pay_tlast  = pay_tvalid && last_beat;
  assign pay_tdata  = pay_tvalid ? data_byte : 8'h00;
  assign pay_tuser  = 1'b0;
  assign ip_id      = ip_id_q;
  assign active     = (state_q != S_IDLE);
  assign pkts_sent  = pkts_q;
  assign done       = done_q;

endmodule

// File: tb/tb_udp_pkt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_udp_pkt_sequencer
//
// Self-checking bench for udp_pkt_sequencer. A table of runs (config, ready
// pattern, optional stop point, expected packet/beat totals) is applied in a
// loop; every accepted beat, header rise and done pulse is captured by a
// monitor and compared against a packet-level model (byte formula, gap
// timing, ip_id progression). Hand-written sequences cover stop during the
// gap, start+stop together and reset in mid-payload; randomized runs follow.
// -----------------------------------------------------------------------------
module tb_udp_pkt_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [10:0] cfg_payload_len;
  logic [15:0] cfg_gap;
  logic [31:0] cfg_pkt_count;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [7:0]  pay_tdata;
  logic        pay_tvalid;
  logic        pay_tready;
  logic        pay_tlast;
  logic        pay_tuser;
  logic [15:0] ip_id;
  logic        active;
  logic [31:0] pkts_sent;
  logic        done;

  udp_pkt_sequencer #(
    .LEN_WIDTH(11),
    .GAP_WIDTH(16),
    .FILL_BYTE(8'h11)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .cfg_payload_len(cfg_payload_len),
    .cfg_gap        (cfg_gap),
    .cfg_pkt_count  (cfg_pkt_count),
    .hdr_valid      (hdr_valid),
    .hdr_ready      (hdr_ready),
    .pay_tdata      (pay_tdata),
    .pay_tvalid     (pay_tvalid),
    .pay_tready     (pay_tready),
    .pay_tlast      (pay_tlast),
    .pay_tuser      (pay_tuser),
    .ip_id          (ip_id),
    .active         (active),
    .pkts_sent      (pkts_sent),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;
  int ip_model = 0;

  // ---------------- monitor ----------------
  logic [7:0]  beat_data_q[$];
  bit          beat_last_q[$];
  logic [15:0] beat_ip_q[$];
  logic [31:0] beat_pkt_q[$];
  int          beat_cyc_q[$];
  int          rise_q[$];
  int          done_q[$];
  int          hs_cnt;
  int          start_cyc;
  int          stop_cyc;
  logic        hdr_prev   = 1'b0;
  logic        stall_prev = 1'b0;
  logic [7:0]  data_prev  = 8'h00;
  logic        last_prev  = 1'b0;

  task automatic chk(input string run, input string what,
                     input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s/%s: got %0h expected %0h", run, what, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      hdr_prev   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("mon", "stall_hold", {pay_tvalid, pay_tdata, pay_tlast},
            {1'b1, data_prev, last_prev});
      if (pay_tvalid && pay_tready) begin
        beat_data_q.push_back(pay_tdata);
        beat_last_q.push_back(pay_tlast);
        beat_ip_q.push_back(ip_id);
        beat_pkt_q.push_back(pkts_sent);
        beat_cyc_q.push_back(cyc);
      end
      if (hdr_valid && !hdr_prev) rise_q.push_back(cyc);
      if (hdr_valid && hdr_ready) hs_cnt++;
      if (done) done_q.push_back(cyc);
      if (start && !active) start_cyc = cyc;
      if (stop) stop_cyc = cyc;
      hdr_prev   = hdr_valid;
      stall_prev = pay_tvalid && !pay_tready;
      data_prev  = pay_tdata;
      last_prev  = pay_tlast;
    end
  end

  // ---------------- reference model ----------------
  function automatic int eff_len(input int len);
`ifdef UDP_SEQ_SEQNUM_EN
    return (len < 4) ? 4 : len;
`else
    return (len == 0) ? 1 : len;
`endif
  endfunction

  function automatic logic [7:0] model_byte(input int pkt, input int i);
    logic [31:0] p;
    p = 32'(pkt);
`ifdef UDP_SEQ_SEQNUM_EN
    if (i < 4) return 8'(p >> (8 * (3 - i)));
`endif
    return 8'((32'h11 + i) % 256);
  endfunction

  task automatic clear_mon();
    beat_data_q.delete();
    beat_last_q.delete();
    beat_ip_q.delete();
    beat_pkt_q.delete();
    beat_cyc_q.delete();
    rise_q.delete();
    done_q.delete();
    hs_cnt = 0;
  endtask

  task automatic start_pulse(input int len, input int gap, input int count);
    @(posedge clk); #1;
    cfg_payload_len = 11'(len);
    cfg_gap         = 16'(gap);
    cfg_pkt_count   = 32'(count);
    start           = 1'b1;
    @(posedge clk); #1;
    start           = 1'b0;
  endtask

  // rmode: 0 = ready always 1, 1 = pay_tready toggles, 2 = random readies.
  task automatic run_check(input string name, input int len, input int gap,
                           input int count, input int rmode, input int stop_pkt,
                           input int exp_pkts, input int exp_beats);
    int L;
    int n_exp;
    bit injected;
    bit stopped;
    L        = eff_len(len);
    n_exp    = (stop_pkt >= 0) ? stop_pkt + 1 : count;
    injected = 1'b0;
    stopped  = 1'b0;
    clear_mon();
    hdr_ready  = 1'b1;
    pay_tready = 1'b1;
    start_pulse(len, gap, count);
    for (int c = 0; c < 4000 && done_q.size() == 0; c++) begin
      start = 1'b0;
      stop  = 1'b0;
      case (rmode)
        0:       pay_tready = 1'b1;
        1:       pay_tready = ~pay_tready;
        default: pay_tready = 1'($urandom_range(0, 1));
      endcase
      hdr_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      // Mid-payload: a second start and new cfg values must be ignored.
      if (!injected && pay_tvalid) begin
        start           = 1'b1;
        cfg_payload_len = 11'($urandom_range(0, 2047));
        cfg_gap         = 16'($urandom_range(0, 9));
        cfg_pkt_count   = $urandom_range(0, 9);
        injected        = 1'b1;
      end
      if (stop_pkt >= 0 && !stopped && beat_data_q.size() == stop_pkt * L + 2) begin
        stop    = 1'b1;
        stopped = 1'b1;
      end
      @(posedge clk); #1;
    end
    start      = 1'b0;
    stop       = 1'b0;
    pay_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    chk(name, "done_count", done_q.size(), 1);
    chk(name, "pkts_sent", pkts_sent, 32'(exp_pkts));
    chk(name, "beats", beat_data_q.size(), 32'(exp_beats));
    chk(name, "model_beats", beat_data_q.size(), 32'(n_exp * L));
    chk(name, "hdr_rises", rise_q.size(), 32'(n_exp));
    chk(name, "hdr_handshakes", hs_cnt, 32'(n_exp));
    chk(name, "idle_after", {active, hdr_valid, pay_tvalid}, 3'b000);
    chk(name, "ip_id_end", ip_id, 16'(ip_model + n_exp));
    if (rise_q.size() > 0)
      chk(name, "first_hdr", rise_q[0], 32'(start_cyc + 1));
    for (int k = 0; k < beat_data_q.size() && k < n_exp * L; k++) begin
      int p;
      int i;
      p = k / L;
      i = k % L;
      chk(name, "beat",
          {beat_data_q[k], beat_last_q[k], beat_ip_q[k], beat_pkt_q[k]},
          {model_byte(p, i), (i == L - 1), 16'(ip_model + p), 32'(p)});
    end
    for (int p = 1; p < rise_q.size() && p * L <= beat_cyc_q.size(); p++)
      chk(name, "gap_timing", rise_q[p], 32'(beat_cyc_q[p * L - 1] + gap + 1));
    if (done_q.size() > 0 && beat_cyc_q.size() > 0)
      chk(name, "done_timing", done_q[0], 32'(beat_cyc_q[beat_cyc_q.size() - 1] + 1));
    $display("run %s: len=%0d gap=%0d count=%0d beats=%0d pkts=%0d ip_id=%0h",
             name, len, gap, count, beat_data_q.size(), pkts_sent, ip_id);
    ip_model = (ip_model + n_exp) % 65536;
  endtask

  // ---------------- table ----------------
  typedef struct {
    string name;
    int    len;
    int    gap;
    int    count;
    int    rmode;
    int    stop_pkt;
    int    exp_pkts;
    int    exp_beats;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int len;
    int count;
    int stop_pkt;

    vecs[0] = '{"len18_single", 18, 0, 1, 0, -1, 1, 18};
    vecs[1] = '{"len4_gap5_x3",  4, 5, 3, 0, -1, 3, 12};
    vecs[2] = '{"toggle_ready", 10, 2, 2, 1, -1, 2, 20};
    vecs[3] = '{"stop_pkt4",     5, 0, 0, 0,  3, 4, 20};
`ifdef UDP_SEQ_SEQNUM_EN
    vecs[4] = '{"len1_rand",     1, 1, 3, 2, -1, 3, 12};
    vecs[5] = '{"len0",          0, 0, 2, 0, -1, 2, 8};
    vecs[6] = '{"len2_seq",      2, 3, 2, 0, -1, 2, 8};
`else
    vecs[4] = '{"len1_rand",     1, 1, 3, 2, -1, 3, 3};
    vecs[5] = '{"len0",          0, 0, 2, 0, -1, 2, 2};
    vecs[6] = '{"len2_seq",      2, 3, 2, 0, -1, 2, 4};
`endif

    reset           = 1'b1;
    start           = 1'b0;
    stop            = 1'b0;
    cfg_payload_len = '0;
    cfg_gap         = '0;
    cfg_pkt_count   = '0;
    hdr_ready       = 1'b1;
    pay_tready      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", "outputs",
        {hdr_valid, pay_tdata, pay_tvalid, pay_tlast, pay_tuser, ip_id, active, pkts_sent, done},
        '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // start and stop together: no run begins.
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    @(posedge clk); #1;
    chk("start_stop", "stays_idle", {active, hdr_valid, done}, 3'b000);

    foreach (vecs[v])
      run_check(vecs[v].name, vecs[v].len, vecs[v].gap, vecs[v].count,
                vecs[v].rmode, vecs[v].stop_pkt, vecs[v].exp_pkts, vecs[v].exp_beats);

    // stop while in the gap: idle next cycle with a done pulse.
    clear_mon();
    start_pulse(4, 20, 0);
    for (int c = 0; c < 200 && beat_data_q.size() < eff_len(4); c++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("gap_stop", "done_count", done_q.size(), 1);
    if (done_q.size() > 0)
      chk("gap_stop", "done_timing", done_q[0], 32'(stop_cyc + 1));
    chk("gap_stop", "pkts_sent", pkts_sent, 1);
    chk("gap_stop", "hdr_rises", rise_q.size(), 1);
    chk("gap_stop", "state", {active, ip_id}, {1'b0, 16'(ip_model + 1)});
    $display("run gap_stop: pkts=%0d ip_id=%0h", pkts_sent, ip_id);
    ip_model = (ip_model + 1) % 65536;

    // reset while on payload byte 7.
    clear_mon();
    start_pulse(18, 0, 1);
    for (int c = 0; c < 200 && beat_data_q.size() < 7; c++) begin
      @(posedge clk); #1;
    end
    chk("reset_pay", "reached_byte7", beat_data_q.size(), 7);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_pay", "outputs",
        {hdr_valid, pay_tdata, pay_tvalid, pay_tlast, pay_tuser, ip_id, active, pkts_sent, done},
        '0);
    $display("run reset_pay: outputs cleared after reset mid-payload");
    ip_model = 0;
    run_check("after_reset", 18, 0, 1, 0, -1, 1, eff_len(18));

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        len      = $urandom_range(3, 24);
        count    = 0;
        stop_pkt = $urandom_range(0, 2);
      end else begin
        len      = $urandom_range(0, 24);
        count    = $urandom_range(1, 3);
        stop_pkt = -1;
      end
      begin
        int gap;
        int n;
        gap = $urandom_range(0, 6);
        n   = (stop_pkt >= 0) ? stop_pkt + 1 : count;
        run_check($sformatf("rand%0d", r), len, gap, count, 2, stop_pkt,
                  n, n * eff_len(len));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
